sonar_ranger: RTL and testbench
===============================

# sonar_ranger

Memory-mapped ultrasonic ranging peripheral that answers processor data-memory accesses in a reserved word-address window, alongside the data RAM. On a store to its control register it emits a fixed-width trigger pulse on an IO pin, then times the returning echo pulse. It exposes busy/done/timeout status and the echo width in clock cycles for the processor to read back. It sits in the FPGA top level on the same `wEn`/`addr`/`dataIn`/`dataOut` bus as the RAM; a registered `hit` steers the top-level read mux.

## Interface
- `BASE_ADDR`, 12'hF00: word address of register 0; window is BASE_ADDR..BASE_ADDR+3.
- `TRIG_CYCLES`, 500: trigger pulse width in clocks (10 us at 50 MHz).
- `TIMEOUT_CYCLES`, 1_900_000: maximum clocks from trigger end to echo fall (38 ms).
- `CM_DIV`, 2900: clocks per centimetre of echo width (58 us at 50 MHz); used only with `SONAR_CM_EN`.
- `clk` in 1: processor clock; all logic on rising edge.
- `CPU_RESETN` in 1: asynchronous, active-low reset.
- `wEn` in 1: processor store strobe.
- `addr` in 12: word address.
- `dataIn` in 32: store data.
- `dataOut` out 32: registered read data.
- `hit` out 1: registered; 1 when the previous-cycle `addr` was in the window.
- `trig` out 1: trigger to sensor.
- `echo` in 1: asynchronous echo from sensor.

## Operation
- Register map (offset from BASE_ADDR):
  - 0 CTRL (W): bit0 = start, bit1 = clear done/timeout. Reads 0.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 timeout, bit3 synchronized echo level; other bits 0.
  - 2 ECHO_CYCLES (R): 32-bit result.
  - 3 ECHO_CM (R): centimetre result.
- Writes to offsets 1–3 are ignored.
- `echo` passes through a 2-flop synchronizer. A rising or falling edge is detected by comparing the synchronized level with a third flop.
- States:
  - IDLE: on start, clear done/timeout/results and go to TRIG.
  - TRIG: `trig`=1 for exactly TRIG_CYCLES clocks, then WAIT_HI.
  - WAIT_HI: on a synchronized rising edge go to MEASURE. A level already high on entry is not a rising edge.
  - MEASURE: increment ECHO_CYCLES each clock while the level is high. On a falling edge, set done and go to IDLE.
- Timeout counter:
  - Runs in WAIT_HI and MEASURE.
  - At TIMEOUT_CYCLES it sets timeout=1 and done=1, and sets ECHO_CYCLES = 32'hFFFF_FFFF and ECHO_CM = 32'hFFFF_FFFF.
  - It then forces IDLE.
- busy = state != IDLE.
- Start while busy is ignored.
- Clear while busy is ignored. Clear in IDLE zeroes done and timeout only; results are unchanged.
- Start and clear in the same write: start wins.
- ECHO_CYCLES saturates at 32'hFFFF_FFFE; only a timeout produces all-ones.

## Timing
- Reset values: `trig`=0, `dataOut`=0, `hit`=0, state IDLE, all status bits and results 0, synchronizer flops 0.
- Reset mid-operation drops `trig` immediately (asynchronously) and discards the measurement.
- A store at edge N (wEn=1, addr=BASE) raises `trig` after edge N+1. `trig` stays high for TRIG_CYCLES clocks, and busy reads 1 from N+1.
- Echo latency: the internal rising-edge detect occurs 3 clocks after `echo` rises, and falling-edge detect occurs 3 clocks after `echo` falls. ECHO_CYCLES therefore equals the pulse width in clocks, ±1.
- done is set on the clock the falling edge is detected.
- Reads are one-cycle latency, matching RAM: `addr` sampled at edge N, with `dataOut` and `hit` valid after edge N. Out-of-window addresses give `hit`=0 and `dataOut`=0.
- A read of STATUS in the same cycle done sets returns the pre-update value.

## Configuration
- `SONAR_CM_EN` defined:
  - A prescaler counts MEASURE clocks modulo CM_DIV and increments ECHO_CM on each wrap.
  - ECHO_CM therefore equals floor(ECHO_CYCLES / CM_DIV).
  - ECHO_CM saturates at 32'hFFFF_FFFE.
- Undefined: no prescaler or ECHO_CM register is built, and offset 3 reads 0.

## Structure
- Shared package `sonar_pkg`: state enum (IDLE, TRIG, WAIT_HI, MEASURE), register offsets, STATUS bit positions, and the 32'hFFFF_FFFF timeout sentinel.
- One sub-module, `sonar_sync`: 2-flop synchronizer plus edge detector, with outputs `level`, `rise`, `fall`.
- The FSM, counters and bus decode stay in `sonar_ranger`.

## Test plan
All scenarios use TRIG_CYCLES=4, TIMEOUT_CYCLES=200, CM_DIV=10.
- Basic range:
  - Stimulus: store 1 to BASE; hold `echo` low 20 clocks after `trig` falls, then high for 57 clocks.
  - Response: `trig` high exactly 4 clocks; STATUS=0x2 after the fall; ECHO_CYCLES in 56..58; with SONAR_CM_EN, ECHO_CM=5.
- No echo:
  - Stimulus: store 1 and never raise `echo`.
  - Response: 200 clocks after trig falls, STATUS=0x6 and ECHO_CYCLES=32'hFFFF_FFFF.
- Stale high echo:
  - Stimulus: `echo` held high before start.
  - Response: no measurement starts until `echo` falls and rises again; otherwise timeout.
- Start while busy:
  - Stimulus: second store of 1 during MEASURE.
  - Response: no new `trig` pulse, and the result is unaffected.
- Reset mid-TRIG:
  - Stimulus: drop CPU_RESETN on the 2nd trig clock.
  - Response: `trig`=0 immediately; all registers read 0 after release.
- Bus decode:
  - Stimulus: read BASE+2 and BASE+4.
  - Response: `hit`=1 with data next cycle for BASE+2; `hit`=0, `dataOut`=0 for BASE+4; stores to BASE+1 change nothing.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar ranging peripheral: FSM state codes,
// register offsets, STATUS/CTRL bit positions and the timeout sentinel.
package sonar_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRIG    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_MEASURE = 2'd3;

    // Register offsets from the base word address
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLES = 2'd2;
    localparam logic [1:0] OFF_CM     = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_LEVEL   = 3;

    // All-ones is reserved to flag a timeout; measured values stop one below.
    localparam logic [31:0] TIMEOUT_SENTINEL = 32'hFFFF_FFFF;
    localparam logic [31:0] RESULT_MAX       = 32'hFFFF_FFFE;

    // Saturating increment that never reaches the timeout sentinel.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v >= RESULT_MAX) ? RESULT_MAX : v + 32'd1;
    endfunction

endpackage

// File: rtl/sonar_sync.sv
// Two-flop synchronizer for the asynchronous echo input, plus a third flop
// used to detect rising and falling edges of the synchronized level.
module sonar_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;

    // Shift the raw input through the synchronizer and edge-history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/sonar_ranger.sv
// Memory-mapped ultrasonic ranger: a store to CTRL fires a trigger pulse,
// then the echo pulse width is timed in clocks with a timeout guard.
// Optional feature macro: SONAR_CM_EN builds the centimetre prescaler and
// the ECHO_CM register; without it offset 3 reads 0.
module sonar_ranger
    import sonar_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR      = 12'hF00,
    parameter int          TRIG_CYCLES    = 500,
    parameter int          TIMEOUT_CYCLES = 1_900_000,
    parameter int          CM_DIV         = 2900
) (
    input  logic        clk,
    input  logic        CPU_RESETN,
    input  logic        wEn,
    input  logic [11:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        hit,
    output logic        trig,
    input  logic        echo
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic              echo_level, echo_rise, echo_fall;
    logic [11:0]       off;
    logic              in_win, wr_ctrl;
    logic [31:0]       rdata;
    logic              count_en, to_hit;

    logic [1:0]        state_q, state_d;
    logic              trig_q, trig_d;
    logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       cycles_q, cycles_d;
    logic              start_q, start_d;
    logic [31:0]       dout_q;
    logic              hit_q;
    logic              unused_bits;

`ifdef SONAR_CM_EN
    localparam int PRE_W = $clog2(CM_DIV + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CM_DIV - 1);
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [31:0]       cm_q, cm_d;
    assign unused_bits = ^dataIn[31:2];
`else
    assign unused_bits = (^dataIn[31:2]) ^ (CM_DIV == 0);
`endif

    sonar_sync u_sync (
        .clk     (clk),
        .rst_n   (CPU_RESETN),
        .async_i (echo),
        .level   (echo_level),
        .rise    (echo_rise),
        .fall    (echo_fall)
    );

    // Window decode: offset wraps modulo 4096, so anything outside reads as >= 4.
    assign off     = addr - BASE_ADDR;
    assign in_win  = (off < 12'd4);
    assign wr_ctrl = wEn && in_win && (off[1:0] == OFF_CTRL);
    assign to_hit  = (to_cnt_q == TO_LAST);

    // Read mux over current register values (pre-update on the sampling edge).
    always_comb begin
        rdata = 32'd0;
        if (in_win) begin
            case (off[1:0])
                OFF_STATUS: begin
                    rdata[STAT_BUSY]    = (state_q != ST_IDLE);
                    rdata[STAT_DONE]    = done_q;
                    rdata[STAT_TIMEOUT] = timeout_q;
                    rdata[STAT_LEVEL]   = echo_level;
                end
                OFF_CYCLES: rdata = cycles_q;
`ifdef SONAR_CM_EN
                OFF_CM:     rdata = cm_q;
`endif
                default:    rdata = 32'd0;
            endcase
        end
    end

    // Ranging FSM, trigger/timeout counters and result accumulation.
    always_comb begin
        state_d    = state_q;
        trig_d     = trig_q;
        trig_cnt_d = trig_cnt_q;
        to_cnt_d   = to_cnt_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        cycles_d   = cycles_q;
        count_en   = 1'b0;
`ifdef SONAR_CM_EN
        presc_d    = presc_q;
        cm_d       = cm_q;
`endif
        // A start is only latched while idle, so a store during busy is dropped.
        start_d = wr_ctrl && dataIn[CTRL_START] && (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d    = ST_TRIG;
                    trig_d     = 1'b1;
                    trig_cnt_d = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    cycles_d   = 32'd0;
`ifdef SONAR_CM_EN
                    presc_d    = '0;
                    cm_d       = 32'd0;
`endif
                end else if (wr_ctrl && dataIn[CTRL_CLEAR] && !dataIn[CTRL_START]) begin
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_TRIG: begin
                if (trig_cnt_q == TRIG_LAST) begin
                    state_d  = ST_WAIT_HI;
                    trig_d   = 1'b0;
                    to_cnt_d = '0;
                end else begin
                    trig_cnt_d = trig_cnt_q + TRIG_W'(1);
                end
            end
            ST_WAIT_HI, ST_MEASURE: begin
                if (to_hit) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    cycles_d  = TIMEOUT_SENTINEL;
`ifdef SONAR_CM_EN
                    cm_d      = TIMEOUT_SENTINEL;
`endif
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (state_q == ST_WAIT_HI) begin
                        // The detect clock itself counts, so the result tracks pulse width.
                        if (echo_rise) begin
                            state_d  = ST_MEASURE;
                            count_en = 1'b1;
                        end
                    end else if (echo_fall) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (echo_level) begin
                        count_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (count_en) begin
            cycles_d = sat_inc(cycles_q);
`ifdef SONAR_CM_EN
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                cm_d    = sat_inc(cm_q);
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
`endif
        end
    end

    // State and bus registers; reset also drops trig asynchronously.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= ST_IDLE;
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycles_q   <= 32'd0;
            start_q    <= 1'b0;
            dout_q     <= 32'd0;
            hit_q      <= 1'b0;
`ifdef SONAR_CM_EN
            presc_q    <= '0;
            cm_q       <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            trig_cnt_q <= trig_cnt_d;
            to_cnt_q   <= to_cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cycles_q   <= cycles_d;
            start_q    <= start_d;
            dout_q     <= rdata;
            hit_q      <= in_win;
`ifdef SONAR_CM_EN
            presc_q    <= presc_d;
            cm_q       <= cm_d;
`endif
        end
    end

    assign dataOut = dout_q;
    assign hit     = hit_q;
    assign trig    = trig_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Self-checking bench for sonar_ranger with TRIG_CYCLES=4,
// TIMEOUT_CYCLES=200, CM_DIV=10. Honors SONAR_CM_EN if defined.
module tb_sonar_ranger;

    localparam logic [11:0] BASE = 12'hF00;
    localparam int TRIGC = 4;
    localparam int TOC   = 200;
    localparam int CMDIV = 10;

    logic        clk = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        wEn = 1'b0;
    logic [11:0] addr = 12'h000;
    logic [31:0] dataIn = 32'd0;
    logic [31:0] dataOut;
    logic        hit;
    logic        trig;
    logic        echo = 1'b0;

    int checks = 0;
    int errors = 0;

    sonar_ranger #(
        .BASE_ADDR      (BASE),
        .TRIG_CYCLES    (TRIGC),
        .TIMEOUT_CYCLES (TOC),
        .CM_DIV         (CMDIV)
    ) dut (
        .clk        (clk),
        .CPU_RESETN (CPU_RESETN),
        .wEn        (wEn),
        .addr       (addr),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .hit        (hit),
        .trig       (trig),
        .echo       (echo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: expected centimetre value for a result, or 0 if not built.
    function automatic logic [31:0] model_cm(input logic [31:0] cyc);
`ifdef SONAR_CM_EN
        if (cyc == 32'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return cyc / CMDIV;
`else
        return 32'd0 + (cyc & 32'd0);
`endif
    endfunction

    task automatic bus_write(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        addr = a; dataIn = v; wEn = 1'b1;
        @(negedge clk);
        wEn = 1'b0; addr = 12'h000; dataIn = 32'd0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        addr = a; wEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = dataOut; h = hit;
        addr = 12'h000;
    endtask

    // Waits (bounded) for trig to rise and counts its high clocks; -1 if it never rose.
    task automatic trig_pulse(output int width);
        int n;
        n = 0;
        width = -1;
        while (trig !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (trig === 1'b1) begin
            width = 0;
            while (trig === 1'b1 && width < 50) begin
                width++;
                @(negedge clk);
            end
        end
    endtask

    // Echo low for gap clocks, high for w clocks, then settle and read results.
    task automatic echo_pulse(input int gap, input int w,
                              output logic [31:0] st, output logic [31:0] cyc,
                              output logic [31:0] cm);
        logic h;
        repeat (gap) @(negedge clk);
        echo = 1'b1;
        repeat (w) @(negedge clk);
        echo = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(BASE + 12'd1, st, h);
        bus_read(BASE + 12'd2, cyc, h);
        bus_read(BASE + 12'd3, cm, h);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic h;
        CPU_RESETN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (trig !== 1'b0 || dataOut !== 32'd0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: trig=%b dataOut=%h hit=%b, required 0/0/0", trig, dataOut, hit);
        end
        CPU_RESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 12'(i), d, h);
            checks++;
            if (d !== 32'd0 || h !== 1'b1) begin
                errors++;
                $display("FAIL reset_reg%0d: data=%h hit=%b, required 0 hit 1", i, d, h);
            end
        end
    endtask

    task automatic test_basic();
        int w;
        logic [31:0] st, cyc, cm;
        bus_write(BASE, 32'd1);
        trig_pulse(w);
        checks++;
        if (w !== TRIGC) begin
            errors++;
            $display("FAIL basic_trig_width: got %0d, required %0d", w, TRIGC);
        end
        echo_pulse(20, 57, st, cyc, cm);
        checks++;
        if (st !== 32'h2) begin
            errors++;
            $display("FAIL basic_status: got %h, required 2", st);
        end
        checks++;
        if (cyc < 32'd56 || cyc > 32'd58) begin
            errors++;
            $display("FAIL basic_cycles: got %0d, required 56..58", cyc);
        end
        checks++;
        if (cm !== model_cm(32'd57)) begin
            errors++;
            $display("FAIL basic_cm: got %0d, required %0d", cm, model_cm(32'd57));
        end
    endtask

    task automatic test_random_ranges();
        int w, gap, tw;
        logic [31:0] st, cyc, cm, lo, hi;
        for (int k = 0; k < 4; k++) begin
            w   = $urandom_range(80, 5);
            gap = $urandom_range(30, 1);
            bus_write(BASE, 32'd1);
            trig_pulse(tw);
            echo_pulse(gap, w, st, cyc, cm);
            checks++;
            if (st !== 32'h2 || tw !== TRIGC) begin
                errors++;
                $display("FAIL rand%0d_status: status=%h trig=%0d, required 2 and %0d", k, st, tw, TRIGC);
            end
            checks++;
            if (cyc + 32'd1 < 32'(w) || cyc > 32'(w + 1)) begin
                errors++;
                $display("FAIL rand%0d_cycles: got %0d, required %0d +-1", k, cyc, w);
            end
            lo = model_cm(32'(w - 1));
            hi = model_cm(32'(w + 1));
            checks++;
            if (cm < lo || cm > hi) begin
                errors++;
                $display("FAIL rand%0d_cm: got %0d, required %0d..%0d", k, cm, lo, hi);
            end
        end
    endtask

    task automatic test_timeout();
        int w;
        logic [31:0] d;
        logic h;
        bus_write(BASE, 32'd1);
        trig_pulse(w);
        repeat (190) @(negedge clk);
        bus_read(BASE + 12'd1, d, h);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL timeout_still_busy: got %h, required 1", d);
        end
        repeat (12) @(negedge clk);
        bus_read(BASE + 12'd1, d, h);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("FAIL timeout_status: got %h, required 6", d);
        end
        bus_read(BASE + 12'd2, d, h);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL timeout_cycles: got %h, required ffffffff", d);
        end
        bus_read(BASE + 12'd3, d, h);
        checks++;
        if (d !== model_cm(32'hFFFF_FFFF)) begin
            errors++;
            $display("FAIL timeout_cm: got %h, required %h", d, model_cm(32'hFFFF_FFFF));
        end
    endtask

    task automatic test_clear();
        int w;
        logic [31:0] d;
        logic h;
        bus_write(BASE, 32'd2);
        bus_read(BASE + 12'd1, d, h);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clear_status: got %h, required 0", d);
        end
        bus_read(BASE + 12'd2, d, h);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL clear_keeps_result: got %h, required ffffffff", d);
        end
        // start and clear together: start wins
        bus_write(BASE, 32'd3);
        trig_pulse(w);
        checks++;
        if (w !== TRIGC) begin
            errors++;
            $display("FAIL start_clear_trig: got %0d, required %0d", w, TRIGC);
        end
        repeat (210) @(negedge clk);
        bus_read(BASE + 12'd1, d, h);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("FAIL start_clear_timeout: got %h, required 6", d);
        end
    endtask

    task automatic test_stale_echo();
        int w, tw;
        logic [31:0] st, cyc, cm;
        logic h;
        echo = 1'b1;
        repeat (5) @(negedge clk);
        bus_write(BASE, 32'd1);
        trig_pulse(tw);
        repeat (30) @(negedge clk);
        bus_read(BASE + 12'd1, st, h);
        checks++;
        if (st !== 32'h9) begin
            errors++;
            $display("FAIL stale_waiting: status=%h, required 9", st);
        end
        echo = 1'b0;
        w = $urandom_range(40, 10);
        echo_pulse(5, w, st, cyc, cm);
        checks++;
        if (st !== 32'h2 || cyc + 32'd1 < 32'(w) || cyc > 32'(w + 1)) begin
            errors++;
            $display("FAIL stale_measure: status=%h cycles=%0d, required 2 and %0d +-1", st, cyc, w);
        end
        // held high throughout: must time out with level still high
        echo = 1'b1;
        repeat (5) @(negedge clk);
        bus_write(BASE, 32'd1);
        trig_pulse(tw);
        repeat (210) @(negedge clk);
        bus_read(BASE + 12'd1, st, h);
        checks++;
        if (st !== 32'hE) begin
            errors++;
            $display("FAIL stale_timeout: status=%h, required e", st);
        end
        echo = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w, tw, extra;
        logic [31:0] st, cyc;
        logic h;
        w = $urandom_range(60, 30);
        extra = 0;
        bus_write(BASE, 32'd1);
        trig_pulse(tw);
        repeat (5) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (i == 10) begin
                addr = BASE; dataIn = 32'd1; wEn = 1'b1;
            end else if (i == 11) begin
                addr = 12'h000; dataIn = 32'd0; wEn = 1'b0;
            end
            if (trig === 1'b1) extra++;
        end
        echo = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (trig === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start_trig: trig high %0d clocks, required 0", extra);
        end
        bus_read(BASE + 12'd1, st, h);
        bus_read(BASE + 12'd2, cyc, h);
        checks++;
        if (st !== 32'h2 || cyc + 32'd1 < 32'(w) || cyc > 32'(w + 1)) begin
            errors++;
            $display("FAIL busy_start_result: status=%h cycles=%0d, required 2 and %0d +-1", st, cyc, w);
        end
    endtask

    task automatic test_bus_decode();
        logic [31:0] d, expc;
        logic h;
        int extra;
        bus_read(BASE + 12'd2, expc, h);
        checks++;
        if (h !== 1'b1 || expc == 32'd0) begin
            errors++;
            $display("FAIL decode_base2: hit=%b data=%h, required hit 1 and nonzero result", h, expc);
        end
        bus_read(BASE + 12'd4, d, h);
        checks++;
        if (h !== 1'b0 || d !== 32'd0) begin
            errors++;
            $display("FAIL decode_base4: hit=%b data=%h, required 0/0", h, d);
        end
        bus_read(BASE - 12'd1, d, h);
        checks++;
        if (h !== 1'b0 || d !== 32'd0) begin
            errors++;
            $display("FAIL decode_below: hit=%b data=%h, required 0/0", h, d);
        end
        bus_read(BASE, d, h);
        checks++;
        if (h !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL decode_ctrl: hit=%b data=%h, required 1/0", h, d);
        end
        extra = 0;
        bus_write(BASE + 12'd1, 32'hFFFF_FFFF);
        bus_write(BASE + 12'd2, 32'h0000_0003);
        bus_write(BASE + 12'd3, 32'h0000_0001);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (trig === 1'b1) extra++;
        end
        bus_read(BASE + 12'd1, d, h);
        checks++;
        if (d !== 32'h2 || extra !== 0) begin
            errors++;
            $display("FAIL decode_ignored_writes_status: status=%h trig_clocks=%0d, required 2 and 0", d, extra);
        end
        bus_read(BASE + 12'd2, d, h);
        checks++;
        if (d !== expc) begin
            errors++;
            $display("FAIL decode_ignored_writes_cycles: got %h, required %h", d, expc);
        end
    endtask

    task automatic test_reset_mid_trig();
        logic [31:0] d;
        logic h;
        bus_write(BASE, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (trig !== 1'b1) begin
            errors++;
            $display("FAIL midtrig_before: trig=%b, required 1", trig);
        end
        CPU_RESETN = 1'b0;
        #1;
        checks++;
        if (trig !== 1'b0) begin
            errors++;
            $display("FAIL midtrig_async_drop: trig=%b, required 0", trig);
        end
        repeat (2) @(negedge clk);
        CPU_RESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 12'(i), d, h);
            checks++;
            if (d !== 32'd0 || trig !== 1'b0) begin
                errors++;
                $display("FAIL midtrig_reg%0d: data=%h trig=%b, required 0/0", i, d, trig);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ranges();
        test_timeout();
        test_clear();
        test_stale_echo();
        test_back_to_back();
        test_bus_decode();
        test_reset_mid_trig();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
